// File: rtl/btn_debouncer_if.sv
// Button-conditioning bus: raw pins towards the debouncer, clean levels and events back.
// master drives the pins (board/test side); slave is the debouncer.
interface btn_debouncer_if #(
    parameter int unsigned N_BTN = 4
);
    logic [N_BTN-1:0] BTN;
    logic [N_BTN-1:0] BTN_STATE;
    logic [N_BTN-1:0] PRESS;
    logic [N_BTN-1:0] RELEASE;
    logic [N_BTN-1:0] TOGGLE;

    modport master (
        output BTN,
        input  BTN_STATE,
        input  PRESS,
        input  RELEASE,
        input  TOGGLE
    );

    modport slave (
        input  BTN,
        output BTN_STATE,
        output PRESS,
        output RELEASE,
        output TOGGLE
    );
endinterface

// File: rtl/btn_debouncer.sv
// Per-button synchroniser, consecutive-cycle bounce filter, press/release pulses and
// a press-toggled latch. All channels are independent; one clock, synchronous reset.
module btn_debouncer #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1250000,
    parameter int unsigned CNT_W           = 21
) (
    input logic            CLK,
    input logic            RST,
    btn_debouncer_if.slave bus
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] s1_q, s1_d;
    logic [N_BTN-1:0] s2_q, s2_d;
    logic [N_BTN-1:0] state_q, state_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] toggle_q, toggle_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

    always_comb begin
        s1_d    = bus.BTN;
        s2_d    = s1_q;
        state_d = state_q;
        for (int i = 0; i < int'(N_BTN); i++) begin
            // Any matching cycle clears the count, so short glitches never accumulate.
            cnt_d[i] = '0;
            if (s2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    state_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press_d   = state_d & ~state_q;
        release_d = ~state_d & state_q;
        toggle_d  = toggle_q ^ press_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q      <= '0;
            s2_q      <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            toggle_q  <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.BTN_STATE = state_q;
    assign bus.PRESS     = press_q;
    assign bus.RELEASE   = release_q;
    assign bus.TOGGLE    = toggle_q;

endmodule

// File: tb/tb_btn_debouncer.sv
// Scoreboard bench for btn_debouncer: stimulus queues expected events, per-DUT monitors
// pop and compare whenever PRESS or RELEASE is non-zero.
module tb_btn_debouncer;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] state;
        logic [3:0] tog;
    } ev_t;

    logic CLK;
    logic RST;
    int   cyc;
    int   checks;
    int   errors;
    ev_t  q_a[$];
    ev_t  q_b[$];
    ev_t  ea;
    ev_t  eb;

    btn_debouncer_if #(.N_BTN(4)) bus_a ();
    btn_debouncer_if #(.N_BTN(4)) bus_b ();

    btn_debouncer #(.N_BTN(4), .DEBOUNCE_CYCLES(8), .CNT_W(4)) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a)
    );

    btn_debouncer #(.N_BTN(4), .DEBOUNCE_CYCLES(1), .CNT_W(4)) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic exp_a(input int c, input logic [3:0] p, input logic [3:0] r,
                         input logic [3:0] s, input logic [3:0] t);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.state = s; e.tog = t;
        q_a.push_back(e);
    endtask

    task automatic exp_b(input int c, input logic [3:0] p, input logic [3:0] r,
                         input logic [3:0] s, input logic [3:0] t);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.state = s; e.tog = t;
        q_b.push_back(e);
    endtask

    always @(negedge CLK) begin
        if ((bus_a.PRESS | bus_a.RELEASE) != 4'b0000) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_event: got press=%b release=%b expected none (cycle %0d)",
                         bus_a.PRESS, bus_a.RELEASE, cyc);
            end else begin
                ea = q_a.pop_front();
                chk("a_event_cycle", cyc, ea.cyc);
                chk("a_press", {28'd0, bus_a.PRESS}, {28'd0, ea.press});
                chk("a_release", {28'd0, bus_a.RELEASE}, {28'd0, ea.rel});
                chk("a_state", {28'd0, bus_a.BTN_STATE}, {28'd0, ea.state});
                chk("a_toggle", {28'd0, bus_a.TOGGLE}, {28'd0, ea.tog});
            end
        end
    end

    always @(negedge CLK) begin
        if ((bus_b.PRESS | bus_b.RELEASE) != 4'b0000) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_event: got press=%b release=%b expected none (cycle %0d)",
                         bus_b.PRESS, bus_b.RELEASE, cyc);
            end else begin
                eb = q_b.pop_front();
                chk("b_event_cycle", cyc, eb.cyc);
                chk("b_press", {28'd0, bus_b.PRESS}, {28'd0, eb.press});
                chk("b_release", {28'd0, bus_b.RELEASE}, {28'd0, eb.rel});
                chk("b_state", {28'd0, bus_b.BTN_STATE}, {28'd0, eb.state});
                chk("b_toggle", {28'd0, bus_b.TOGGLE}, {28'd0, eb.tog});
            end
        end
    end

    initial begin
        int p;
        checks    = 0;
        errors    = 0;
        RST       = 1'b1;
        bus_a.BTN = 4'b0000;
        bus_b.BTN = 4'b0000;
        step(3);
        RST = 1'b0;

        chk("reset_state", {28'd0, bus_a.BTN_STATE}, 32'd0);
        chk("reset_press", {28'd0, bus_a.PRESS}, 32'd0);
        chk("reset_release", {28'd0, bus_a.RELEASE}, 32'd0);
        chk("reset_toggle", {28'd0, bus_a.TOGGLE}, 32'd0);
        chk("reset_toggle_b", {28'd0, bus_b.TOGGLE}, 32'd0);

        // Clean press and release on channel 0.
        bus_a.BTN = 4'b0001; p = cyc;
        exp_a(p + 10, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        step(15);
        bus_a.BTN = 4'b0000; p = cyc;
        exp_a(p + 10, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        step(15);

        // Bounce on channel 1: 5 high, 2 low, 3 high, low; nothing may be accepted.
        bus_a.BTN = 4'b0010; step(5);
        bus_a.BTN = 4'b0000; step(2);
        bus_a.BTN = 4'b0010; step(3);
        bus_a.BTN = 4'b0000; step(15);
        chk("bounce_state", {28'd0, bus_a.BTN_STATE}, 32'd0);
        chk("bounce_toggle", {28'd0, bus_a.TOGGLE}, 32'd1);
        bus_a.BTN = 4'b0010; p = cyc;
        exp_a(p + 10, 4'b0010, 4'b0000, 4'b0010, 4'b0011);
        step(20);
        bus_a.BTN = 4'b0000; p = cyc;
        exp_a(p + 10, 4'b0000, 4'b0010, 4'b0000, 4'b0011);
        step(15);

        // Press, long hold, release, press again on channel 2.
        bus_a.BTN = 4'b0100; p = cyc;
        exp_a(p + 10, 4'b0100, 4'b0000, 4'b0100, 4'b0111);
        step(30);
        bus_a.BTN = 4'b0000; p = cyc;
        exp_a(p + 10, 4'b0000, 4'b0100, 4'b0000, 4'b0111);
        step(20);
        bus_a.BTN = 4'b0100; p = cyc;
        exp_a(p + 10, 4'b0100, 4'b0000, 4'b0100, 4'b0011);
        step(20);
        bus_a.BTN = 4'b0000; p = cyc;
        exp_a(p + 10, 4'b0000, 4'b0100, 4'b0000, 4'b0011);
        step(20);

        // All channels at once, then a partial release.
        bus_a.BTN = 4'b1111; p = cyc;
        exp_a(p + 10, 4'b1111, 4'b0000, 4'b1111, 4'b1100);
        step(20);
        bus_a.BTN = 4'b1010; p = cyc;
        exp_a(p + 10, 4'b0000, 4'b0101, 4'b1010, 4'b1100);
        step(20);
        bus_a.BTN = 4'b0000; p = cyc;
        exp_a(p + 10, 4'b0000, 4'b1010, 4'b0000, 4'b1100);
        step(20);

        // Reset in the middle of a count on channel 3 with the button kept held.
        bus_a.BTN = 4'b1000;
        step(6);
        RST = 1'b1;
        step(1);
        RST = 1'b0; p = cyc;
        chk("midreset_toggle", {28'd0, bus_a.TOGGLE}, 32'd0);
        chk("midreset_state", {28'd0, bus_a.BTN_STATE}, 32'd0);
        exp_a(p + 10, 4'b1000, 4'b0000, 4'b1000, 4'b1000);
        step(20);
        bus_a.BTN = 4'b0000; p = cyc;
        exp_a(p + 10, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
        step(20);

        // Single-cycle pulse through the DEBOUNCE_CYCLES=1 instance.
        bus_b.BTN = 4'b0001; p = cyc;
        exp_b(p + 3, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        exp_b(p + 4, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        step(1);
        bus_b.BTN = 4'b0000;
        step(10);

        chk("a_events_pending", q_a.size(), 32'd0);
        chk("b_events_pending", q_b.size(), 32'd0);
        chk("final_toggle_a", {28'd0, bus_a.TOGGLE}, 32'd8);
        chk("final_toggle_b", {28'd0, bus_b.TOGGLE}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
